id_stage: RTL

- Decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes fs_to_ds_reg_valid / fs_data, returning fs_ds_reg_allow_in and branch_data.
- It holds the fs/ds pipeline register, the 32x32 register file with write-back bypass, and the RAW interlock.
- It resolves branches and jumps in decode and emits a decoded bundle to the execute stage.

---
 rtl/id_stage.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Decode stage of a 5-stage RV32I pipeline: fs/ds pipeline register,
// 32x32 register file with write-back bypass, RAW interlock against
// EX/MEM destinations, and branch/jump resolution in decode.
module id_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DS_W     = 140
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fs_to_ds_reg_valid,
    input  logic [63:0]     fs_data,
    output logic            fs_ds_reg_allow_in,
    output logic [32:0]     branch_data,
    input  logic            es_allow_in,
    output logic            ds_to_es_valid,
    output logic [DS_W-1:0] ds_data,
    input  logic [4:0]      es_dest,
    input  logic [4:0]      ms_dest,
    input  logic            ws_rf_we,
    input  logic [4:0]      ws_rf_waddr,
    input  logic [31:0]     ws_rf_wdata
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASS2 = 4'd10;

    logic        ds_valid_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] rf_reg [32];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;

    logic [3:0]  arith_op;
    logic [3:0]  alu_op;
    logic [31:0] src1, src2, store_val;
    logic        rf_we_raw, mem_re, mem_we;
    logic        use_rs1, use_rs2;
    logic        is_jal, is_jalr, is_branch;
    logic        cond_true;
    logic        stall, ds_ready_go, br_taken;
    logic [31:0] br_target;

    assign opcode = instr_reg[6:0];
    assign funct3 = instr_reg[14:12];
    assign rd     = instr_reg[11:7];
    assign rs1    = instr_reg[19:15];
    assign rs2    = instr_reg[24:20];

    assign imm_i = {{20{instr_reg[31]}}, instr_reg[31:20]};
    assign imm_s = {{20{instr_reg[31]}}, instr_reg[31:25], instr_reg[11:7]};
    assign imm_b = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                    instr_reg[30:25], instr_reg[11:8], 1'b0};
    assign imm_u = {instr_reg[31:12], 12'd0};
    assign imm_j = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12],
                    instr_reg[20], instr_reg[30:21], 1'b0};

    // Register file: x0 is never written; cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
        end else if (ws_rf_we && ws_rf_waddr != 5'd0) begin
            rf_reg[ws_rf_waddr] <= ws_rf_wdata;
        end
    end

    // Reads see a same-cycle write-back before it lands in the array.
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                     (ws_rf_we && ws_rf_waddr == rs1) ? ws_rf_wdata : rf_reg[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                     (ws_rf_we && ws_rf_waddr == rs2) ? ws_rf_wdata : rf_reg[rs2];

    // Arithmetic operation shared by OP and OP-IMM; SUB only exists in OP.
    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            3'b000: arith_op = (opcode == OPC_OP && instr_reg[30]) ? ALU_SUB : ALU_ADD;
            3'b001: arith_op = ALU_SLL;
            3'b010: arith_op = ALU_SLT;
            3'b011: arith_op = ALU_SLTU;
            3'b100: arith_op = ALU_XOR;
            3'b101: arith_op = instr_reg[30] ? ALU_SRA : ALU_SRL;
            3'b110: arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    // Main decode: operands, control bits and which source registers matter.
    always_comb begin
        alu_op    = ALU_ADD;
        src1      = '0;
        src2      = '0;
        store_val = '0;
        rf_we_raw = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_op = ALU_PASS2; src2 = imm_u; rf_we_raw = 1'b1;
            end
            OPC_AUIPC: begin
                src1 = pc_reg; src2 = imm_u; rf_we_raw = 1'b1;
            end
            OPC_JAL: begin
                src1 = pc_reg; src2 = 32'd4; rf_we_raw = 1'b1; is_jal = 1'b1;
            end
            OPC_JALR: begin
                src1 = pc_reg; src2 = 32'd4; rf_we_raw = 1'b1; is_jalr = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                src1 = rs1_val; src2 = rs2_val; is_branch = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                src1 = rs1_val; src2 = imm_i; rf_we_raw = 1'b1; mem_re = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                src1 = rs1_val; src2 = imm_s; mem_we = 1'b1; store_val = rs2_val;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                alu_op = arith_op; src1 = rs1_val; rf_we_raw = 1'b1; use_rs1 = 1'b1;
                src2 = (funct3 == 3'b001 || funct3 == 3'b101) ?
                       {27'd0, instr_reg[24:20]} : imm_i;
            end
            OPC_OP: begin
                alu_op = arith_op; src1 = rs1_val; src2 = rs2_val; rf_we_raw = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Conditional branch comparison on the (bypassed) register values.
    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            3'b000: cond_true = (rs1_val == rs2_val);
            3'b001: cond_true = (rs1_val != rs2_val);
            3'b100: cond_true = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101: cond_true = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: cond_true = (rs1_val <  rs2_val);
            3'b111: cond_true = (rs1_val >= rs2_val);
            default: cond_true = 1'b0;
        endcase
    end

    // Full interlock: no forwarding from EX/MEM, so any live producer stalls.
    assign stall = ds_valid_reg &&
                   ((use_rs1 && rs1 != 5'd0 && (rs1 == es_dest || rs1 == ms_dest)) ||
                    (use_rs2 && rs2 != 5'd0 && (rs2 == es_dest || rs2 == ms_dest)));
    assign ds_ready_go        = ~stall;
    assign fs_ds_reg_allow_in = ~ds_valid_reg | (ds_ready_go & es_allow_in);
    assign ds_to_es_valid     = ds_valid_reg & ds_ready_go;

    assign br_taken = ds_valid_reg & ds_ready_go & es_allow_in &
                      (is_jal | is_jalr | (is_branch & cond_true));

    // Redirect target; forced to zero when nothing is taken.
    always_comb begin
        br_target = '0;
        if (br_taken) begin
            if (is_jal)       br_target = pc_reg + imm_j;
            else if (is_jalr) br_target = (rs1_val + imm_i) & ~32'd1;
            else              br_target = pc_reg + imm_b;
        end
    end

    assign branch_data = {br_taken, br_target};

    assign ds_data = {pc_reg, alu_op, src1, src2, store_val, rd,
                      rf_we_raw & (rd != 5'd0), mem_re, mem_we};

    // fs/ds pipeline register; the fetch slot is squashed on a taken redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_valid_reg <= 1'b0;
            pc_reg       <= PC_RESET;
            instr_reg    <= '0;
        end else if (fs_ds_reg_allow_in) begin
            ds_valid_reg <= fs_to_ds_reg_valid & ~br_taken;
            if (fs_to_ds_reg_valid) begin
                pc_reg    <= fs_data[63:32];
                instr_reg <= fs_data[31:0];
            end
        end
    end

endmodule
